// File: rtl/tcm_arb_pkg.sv
// rtl/tcm_arb_pkg.sv - shared owner encoding and address-check helpers for tcm_port_arb
package tcm_arb_pkg;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  function automatic int calc_ob(input int dw);
    return (dw == 64) ? 3 : 2;
  endfunction

  // In-window and naturally aligned for a word of 2^ob bytes
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input int aw, input int ob);
    logic [31:0] lo_mask;
    logic [31:0] hi_mask;
    lo_mask = (32'd1 << ob) - 32'd1;
    hi_mask = ~((32'd1 << (aw + ob)) - 32'd1);
    return (((addr ^ base) & hi_mask) == 32'd0) && ((addr & lo_mask) == 32'd0);
  endfunction

endpackage

// File: rtl/tcm_port_arb_if.sv
// rtl/tcm_port_arb_if.sv - per-master request/response bundle for tcm_port_arb
interface tcm_port_arb_if #(parameter int DW = 32);

  logic            req;
  logic            we;
  logic [31:0]     addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  logic            err;

  modport master (output req, we, addr, wdata, wstrb,
                  input  gnt, rvalid, rdata, err);

  modport slave  (input  req, we, addr, wdata, wstrb,
                  output gnt, rvalid, rdata, err);

endinterface

// File: rtl/tcm_arb_pick.sv
// rtl/tcm_arb_pick.sv - one-hot grant selection; round-robin with last_gnt when TCM_ARB_RR_EN is defined
module tcm_arb_pick
  import tcm_arb_pkg::*;
#(
  parameter bit M1_HIGH_PRIO = 1'b1
) (
`ifdef TCM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic pick1;

`ifdef TCM_ARB_RR_EN
  logic last_gnt;

  // Reset to M1 so the first tie goes to M0
  assign pick1 = req1 && (!req0 || (last_gnt == OWN_M0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= OWN_M1;
    end else if (req0 || req1) begin
      last_gnt <= pick1 ? OWN_M1 : OWN_M0;
    end
  end
`else
  assign pick1 = req1 && (!req0 || M1_HIGH_PRIO);
`endif

  assign gnt1 = pick1;
  assign gnt0 = req0 && !pick1;

endmodule

// File: rtl/tcm_port_arb.sv
// rtl/tcm_port_arb.sv - two-master to single-port TCM arbiter; TCM_ARB_RR_EN selects round-robin
module tcm_port_arb
  import tcm_arb_pkg::*;
#(
  parameter int          AW           = 12,
  parameter int          DW           = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          M1_HIGH_PRIO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  tcm_port_arb_if.slave   m0,
  tcm_port_arb_if.slave   m1,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int OB = calc_ob(DW);

  logic            gnt0;
  logic            gnt1;
  logic            any_gnt;
  logic            win_we;
  logic [31:0]     win_addr;
  logic [DW-1:0]   win_wdata;
  logic [DW/8-1:0] win_wstrb;
  logic            win_ok;

  logic rsp_vld;
  logic rsp_owner;
  logic rsp_err;
  logic rsp_rd;
  logic rv0;
  logic rv1;
  logic rd_ok;

  tcm_arb_pick #(
    .M1_HIGH_PRIO (M1_HIGH_PRIO != 0)
  ) u_pick (
`ifdef TCM_ARB_RR_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req0  (m0.req),
    .req1  (m1.req),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign m0.gnt  = gnt0;
  assign m1.gnt  = gnt1;
  assign any_gnt = gnt0 || gnt1;

  // Without a grant the memory side simply follows M0
  assign win_we    = gnt1 ? m1.we    : m0.we;
  assign win_addr  = gnt1 ? m1.addr  : m0.addr;
  assign win_wdata = gnt1 ? m1.wdata : m0.wdata;
  assign win_wstrb = gnt1 ? m1.wstrb : m0.wstrb;
  assign win_ok    = addr_ok(win_addr, BASE_ADDR, AW, OB);

  assign mem_en    = any_gnt && win_ok;
  assign mem_we    = mem_en && win_we;
  assign mem_addr  = win_addr[AW+OB-1:OB];
  assign mem_wdata = win_wdata;
  assign mem_wstrb = win_we ? win_wstrb : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld   <= 1'b0;
      rsp_owner <= OWN_M0;
      rsp_err   <= 1'b0;
      rsp_rd    <= 1'b0;
    end else begin
      rsp_vld   <= any_gnt;
      rsp_owner <= gnt1 ? OWN_M1 : OWN_M0;
      rsp_err   <= any_gnt && !win_ok;
      rsp_rd    <= !win_we;
    end
  end

  assign rv0   = rsp_vld && (rsp_owner == OWN_M0);
  assign rv1   = rsp_vld && (rsp_owner == OWN_M1);
  assign rd_ok = rsp_rd && !rsp_err;

  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.err    = rv0 && rsp_err;
  assign m1.err    = rv1 && rsp_err;
  assign m0.rdata  = (rv0 && rd_ok) ? mem_rdata : '0;
  assign m1.rdata  = (rv1 && rd_ok) ? mem_rdata : '0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// tb/tb_tcm_port_arb.sv - directed scoreboard bench for tcm_port_arb; TCM_ARB_RR_EN adds the round-robin sequence
module tb_tcm_port_arb;
  import tcm_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tcm_port_arb_if #(.DW(DW)) m0 ();
  tcm_port_arb_if #(.DW(DW)) m1 ();

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata = '0;

  tcm_port_arb #(
    .AW           (AW),
    .DW           (DW),
    .BASE_ADDR    (32'h0000_0000),
    .M1_HIGH_PRIO (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0),
    .m1        (m1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] tcm [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < DW/8; b++)
          if (mem_wstrb[b]) tcm[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tcm[mem_addr];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic        owner;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] wd [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    if ((sb.size() > 0) && (sb[0].cyc < cyc)) begin
      e = sb.pop_front();
      chk("m0_rvalid", m0.rvalid, e.owner == OWN_M0);
      chk("m1_rvalid", m1.rvalid, e.owner == OWN_M1);
      chk("rsp_err", (e.owner == OWN_M1) ? m1.err : m0.err, e.err);
      chk("rsp_rdata", (e.owner == OWN_M1) ? m1.rdata : m0.rdata, e.data);
    end else begin
      chk("no_rvalid", {m0.rvalid, m1.rvalid}, 2'b00);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_rsp();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drv(input logic m, input logic req, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    if (m == OWN_M0) begin
      m0.req = req; m0.we = we; m0.addr = a; m0.wdata = d; m0.wstrb = s;
    end else begin
      m1.req = req; m1.we = we; m1.addr = a; m1.wdata = d; m1.wstrb = s;
    end
  endtask

  task automatic idle();
    drv(OWN_M0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv(OWN_M1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic expect_grant(input logic m, input logic err, input logic [31:0] data);
    chk("m0_gnt", m0.gnt, m == OWN_M0);
    chk("m1_gnt", m1.gnt, m == OWN_M1);
    sb.push_back('{cyc: cyc, owner: m, err: err, data: data});
  endtask

  initial begin
    wd[0] = 32'h1111_0000;
    wd[1] = 32'h3333_4444;
    wd[2] = 32'h2222_2222;
    wd[3] = 32'hAAAA_BBBB;
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_gnt", m0.gnt, 1'b0);
    chk("rst_m1_gnt", m1.gnt, 1'b0);
    chk("rst_m0_rvalid", m0.rvalid, 1'b0);
    chk("rst_m1_rvalid", m1.rvalid, 1'b0);
    chk("rst_m0_err", m0.err, 1'b0);
    chk("rst_m1_err", m1.err, 1'b0);
    chk("rst_m0_rdata", m0.rdata, 32'h0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("idle_mem_en", mem_en, 1'b0);
    chk("idle_mem_we", mem_we, 1'b0);
    tick();

    // Single write then read of word 4
    drv(OWN_M0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    #1;
    expect_grant(OWN_M0, 1'b0, 32'h0);
    chk("wr_mem_en", mem_en, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 12'd4);
    chk("wr_mem_wstrb", mem_wstrb, 4'hF);
    tick();
    drv(OWN_M0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    expect_grant(OWN_M0, 1'b0, 32'hDEAD_BEEF);
    chk("rd_mem_addr", mem_addr, 12'd4);
    chk("rd_mem_we", mem_we, 1'b0);
    chk("rd_mem_wstrb", mem_wstrb, 4'h0);
    tick();
    idle();
    tick();

    // Back-to-back writes then reads
    for (int i = 0; i < 4; i++) begin
      drv(OWN_M0, 1'b1, 1'b1, 32'(4 * i), wd[i], 4'hF);
      #1;
      expect_grant(OWN_M0, 1'b0, 32'h0);
      chk("b2b_wr_addr", mem_addr, 12'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drv(OWN_M0, 1'b1, 1'b0, 32'(4 * i), 32'h0, 4'h0);
      #1;
      expect_grant(OWN_M0, 1'b0, wd[i]);
      chk("b2b_rd_en", mem_en, 1'b1);
      tick();
    end
    idle();
    tick();

`ifndef TCM_ARB_RR_EN
    // Tie under fixed priority: M1 first, M0 held and granted next
    drv(OWN_M0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    drv(OWN_M1, 1'b1, 1'b1, 32'hC, 32'h1234_5678, 4'b0011);
    #1;
    expect_grant(OWN_M1, 1'b0, 32'h0);
    chk("tie_mem_addr", mem_addr, 12'd3);
    chk("tie_mem_wstrb", mem_wstrb, 4'b0011);
    tick();
    drv(OWN_M1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    expect_grant(OWN_M0, 1'b0, 32'h2222_2222);
    tick();
    drv(OWN_M0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    #1;
    expect_grant(OWN_M0, 1'b0, 32'hAAAA_5678);
    tick();
    idle();
    tick();
`endif

    // Out-of-range and misaligned requests
    drv(OWN_M1, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    #1;
    expect_grant(OWN_M1, 1'b1, 32'h0);
    chk("oor_mem_en", mem_en, 1'b0);
    tick();
    drv(OWN_M1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv(OWN_M0, 1'b1, 1'b0, 32'h2, 32'h0, 4'h0);
    #1;
    expect_grant(OWN_M0, 1'b1, 32'h0);
    chk("mis_mem_en", mem_en, 1'b0);
    tick();
    idle();
    tick();

    // Zero-strobe write is acknowledged but changes nothing
    drv(OWN_M0, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0);
    #1;
    expect_grant(OWN_M0, 1'b0, 32'h0);
    chk("ws0_mem_en", mem_en, 1'b1);
    chk("ws0_mem_wstrb", mem_wstrb, 4'h0);
    tick();
    drv(OWN_M0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    expect_grant(OWN_M0, 1'b0, 32'hDEAD_BEEF);
    tick();
    idle();
    tick();

    // Reset with a read response pending
    drv(OWN_M0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    chk("prerst_m0_gnt", m0.gnt, 1'b1);
    tick();
    rst_n = 1'b0;
    idle();
    #1;
    chk("inrst_m0_rvalid", m0.rvalid, 1'b0);
    chk("inrst_m0_rdata", m0.rdata, 32'h0);
    chk("inrst_mem_en", mem_en, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("inrst_rvalid", {m0.rvalid, m1.rvalid}, 2'b00);
      chk("inrst_err", {m0.err, m1.err}, 2'b00);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();

`ifdef TCM_ARB_RR_EN
    // Continuous tie right after reset alternates starting with M0
    drv(OWN_M0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drv(OWN_M1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k % 2 == 0) expect_grant(OWN_M0, 1'b0, wd[0]);
      else            expect_grant(OWN_M1, 1'b0, wd[1]);
      tick();
    end
    idle();
    tick();
    tick();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
